// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the front end of the core:
//   NOP              - canonical no-op (addi x0,x0,0) shown to decode when idle
//   fetch_state_t    - fetch FSM encoding (IDLE / REQ / ISSUE)
//   RESET_PC_DEFAULT - default architectural PC after reset
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ISSUE = 2'd2
   } fetch_state_t;

endpackage : riscv_pkg

// File: rtl/fetch_perf_cnt.sv
// -----------------------------------------------------------------------------
// fetch_perf_cnt
// Performance counters for the fetch stage. Only present when the build
// defines FETCH_PERF_CNT_EN.
//   clk, rst_n  - clock, asynchronous active-low reset
//   fetch_inc   - one accepted instruction-memory response this cycle
//   stall_inc   - one cycle spent holding an instruction under stall
//   fetch_cnt   - accepted fetches since reset (wraps at 2^32)
//   stall_cnt   - stalled issue cycles since reset (wraps at 2^32)
// -----------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_inc,
   input  logic        stall_inc,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
         if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule : fetch_perf_cnt
`endif

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Owns the architectural PC, fetches one word at a
// time from instruction memory over a req/ack handshake and holds it for
// decode until it retires, then selects the next PC (pc+4 or an aligned
// branch/jump target).
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   PCSel        - 1: next PC is alu_out (low two bits cleared); 0: pc+4
//   alu_out      - branch/jump target from execute
//   stall        - hold the current instruction, do not advance the PC
//   imem_req     - fetch request (held until imem_ack)
//   imem_addr    - fetch address, always equal to pc
//   imem_rdata   - instruction word, valid with imem_ack
//   imem_ack     - memory response strobe (ignored outside REQ)
//   inst         - instruction presented to decode
//   inst_valid   - inst is fetched and not yet retired
//   pc, pc_plus4 - address of inst and its sequential successor
//
// Build option FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt outputs.
// -----------------------------------------------------------------------------
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int                 AWIDTH   = 32,
   parameter int                 DWIDTH   = 32,
   parameter logic [AWIDTH-1:0]  RESET_PC = AWIDTH'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              PCSel,
   input  logic [AWIDTH-1:0] alu_out,
   input  logic              stall,
   output logic              imem_req,
   output logic [AWIDTH-1:0] imem_addr,
   input  logic [DWIDTH-1:0] imem_rdata,
   input  logic              imem_ack,
   output logic [DWIDTH-1:0] inst,
   output logic              inst_valid,
   output logic [AWIDTH-1:0] pc,
   output logic [AWIDTH-1:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       stall_cnt
`endif
);

   fetch_state_t      state, state_next;
   logic              ack_accept;
   logic              retire;
   logic              issue_stall;
   logic [AWIDTH-1:0] branch_target;

   assign pc_plus4  = pc + AWIDTH'(4);   // wraps modulo 2^AWIDTH
   assign imem_addr = pc;

   // Clearing the low two bits aligns every target, including the JALR
   // bit-0 clear; misaligned targets are silently rounded down.
   assign branch_target = alu_out & ~AWIDTH'(3);

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      inst_valid  = 1'b0;
      ack_accept  = 1'b0;
      retire      = 1'b0;
      issue_stall = 1'b0;
      case (state)
         IDLE: state_next = REQ;
         REQ: begin
            imem_req   = 1'b1;
            ack_accept = imem_ack;
            if (imem_ack) state_next = ISSUE;
         end
         ISSUE: begin
            inst_valid  = 1'b1;
            issue_stall = stall;
            retire      = !stall;
            if (!stall) state_next = REQ;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; the asynchronous reset drops imem_req without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
         inst  <= DWIDTH'(NOP);
      end else begin
         state <= state_next;
         if (ack_accept) inst <= imem_rdata;
         if (retire)     pc   <= PCSel ? branch_target : pc_plus4;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   fetch_perf_cnt u_perf_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .fetch_inc (ack_accept),
      .stall_inc (issue_stall),
      .fetch_cnt (fetch_cnt),
      .stall_cnt (stall_cnt)
   );
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Inputs are driven and outputs sampled on the
// falling clock edge; expected fetches are queued when the memory response is
// driven and compared when the instruction is presented to decode.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
   import riscv_pkg::*;

   localparam int AWIDTH = 32;
   localparam int DWIDTH = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              PCSel;
   logic [AWIDTH-1:0] alu_out;
   logic              stall;
   logic              imem_req;
   logic [AWIDTH-1:0] imem_addr;
   logic [DWIDTH-1:0] imem_rdata;
   logic              imem_ack;
   logic [DWIDTH-1:0] inst;
   logic              inst_valid;
   logic [AWIDTH-1:0] pc;
   logic [AWIDTH-1:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]       fetch_cnt;
   logic [31:0]       stall_cnt;
`endif

   fetch_unit #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .PCSel      (PCSel),
      .alu_out    (alu_out),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt  (fetch_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        sb[$];
   int          n_checks  = 0;
   int          n_fail    = 0;
   int          n_fetch   = 0;
   logic [31:0] exp_pc    = 32'h0000_0000;
   logic [31:0] last_inst = NOP;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_req();
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("req_seen", 32'(imem_req), 32'd1);
   endtask

   // Instruction now in ISSUE: compare against the oldest queued fetch.
   task automatic check_issue();
      exp_t e;
      check("issue_valid", 32'(inst_valid), 32'd1);
      check("issue_req_low", 32'(imem_req), 32'd0);
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("inst", inst, e.inst);
         check("pc", pc, e.pc);
         check("pc_plus4", pc_plus4, e.pc + 32'd4);
         last_inst = e.inst;
      end
   endtask

   task automatic fetch(input logic [31:0] data, input int wait_cycles);
      wait_req();
      check("imem_addr", imem_addr, exp_pc);
      for (int i = 0; i < wait_cycles; i++) begin
         tick();
         check("wait_req", 32'(imem_req), 32'd1);
         check("wait_addr", imem_addr, exp_pc);
         check("wait_valid", 32'(inst_valid), 32'd0);
         check("wait_inst", inst, last_inst);
      end
      imem_rdata = data;
      imem_ack   = 1'b1;
      sb.push_back('{pc: exp_pc, inst: data});
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      n_fetch++;
      check_issue();
   endtask

   task automatic retire(input logic sel, input logic [31:0] target);
      stall   = 1'b0;
      PCSel   = sel;
      alu_out = target;
      exp_pc  = sel ? {target[31:2], 2'b00} : exp_pc + 32'd4;
      tick();
      PCSel   = 1'($urandom);
      alu_out = $urandom;
      check("retire_valid_low", 32'(inst_valid), 32'd0);
      check("retire_req", 32'(imem_req), 32'd1);
      check("retire_pc", pc, exp_pc);
      check("retire_addr", imem_addr, exp_pc);
   endtask

   initial begin
      rst_n      = 1'b0;
      PCSel      = 1'b0;
      alu_out    = '0;
      stall      = 1'b0;
      imem_rdata = '0;
      imem_ack   = 1'b0;
      tick();

      // Reset state
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, NOP);
      check("rst_pc", pc, 32'h0000_0000);
      check("rst_pc_plus4", pc_plus4, 32'h0000_0004);

      // 1: first request one cycle after release, zero-wait response
      rst_n = 1'b1;
      tick();
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, 32'h0000_0000);
      fetch(32'h0000_0093, 0);
      retire(1'b0, 32'h0);

      // 2: sequential run (addresses 4, 8 follow the first at 0)
      fetch(32'h0010_0113, 0);
      retire(1'b0, 32'h0);
      fetch(32'h0020_0193, 0);

      // 3: taken branch with an unaligned target
      retire(1'b1, 32'h0000_0103);
      check("branch_pc", pc, 32'h0000_0100);
      fetch(32'h0030_0213, 0);

      // 4: three stalled cycles; PCSel toggles and a stray ack is injected
      for (int i = 0; i < 3; i++) begin
         stall      = 1'b1;
         PCSel      = i[0];
         alu_out    = $urandom;
         imem_ack   = (i == 1);
         imem_rdata = 32'hDEAD_BEEF;
         tick();
         imem_ack   = 1'b0;
         check("stall_inst", inst, last_inst);
         check("stall_pc", pc, exp_pc);
         check("stall_valid", 32'(inst_valid), 32'd1);
         check("stall_req", 32'(imem_req), 32'd0);
      end
`ifdef FETCH_PERF_CNT_EN
      check("stall_cnt", stall_cnt, 32'd3);
      check("fetch_cnt", fetch_cnt, 32'(n_fetch));
`endif
      retire(1'b0, 32'h0);

      // 5: four memory wait cycles
      fetch(32'h0040_0293, 4);

      // 6: wrap at the top of the address space (target bits 1:0 cleared)
      retire(1'b1, 32'hFFFF_FFFF);
      fetch(32'h0050_0313, 0);
      retire(1'b0, 32'h0);
      check("wrap_addr", imem_addr, 32'h0000_0000);

      // Asynchronous reset while requesting, between clock edges
      wait_req();
      #2 rst_n = 1'b0;
      #1;
      check("async_req", 32'(imem_req), 32'd0);
      check("async_pc", pc, 32'h0000_0000);
      check("async_inst", inst, NOP);
      check("async_valid", 32'(inst_valid), 32'd0);
      sb.delete();
      tick();

      // Release with a stray ack while IDLE: it must be ignored
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      rst_n      = 1'b1;
      tick();
      imem_ack   = 1'b0;
      check("idle_ack_inst", inst, NOP);
      check("idle_ack_valid", 32'(inst_valid), 32'd0);
      exp_pc    = 32'h0000_0000;
      last_inst = NOP;
      n_fetch   = 0;
`ifdef FETCH_PERF_CNT_EN
      check("rst_fetch_cnt", fetch_cnt, 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
      fetch(32'h0060_0393, 1);
      retire(1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("final_fetch_cnt", fetch_cnt, 32'(n_fetch));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fetch_unit
